// File: rtl/wb_regfile.sv
// Write-back stage: selects WB value/destination, commits to the 32x32 register file,
// serves two decode read ports with write-through bypass and counts retired instructions.
module wb_regfile #(
   parameter logic [31:0] NOP      = 32'h0000_0020,
   parameter logic [4:0]  LINK_REG = 5'd31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_stall,
   input  logic        wb_memtoreg,
   input  logic        wb_regwrite,
   input  logic        wb_regdst,
   input  logic        wb_link,
   input  logic [31:0] wb_alu_data,
   input  logic [31:0] wb_mem_data,
   input  logic [8:0]  wb_pc_4,
   input  logic [31:0] wb_inst,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   output logic [31:0] rd_data_a,
   output logic [31:0] rd_data_b,
   output logic        wb_wr_en,
   output logic [4:0]  wb_wr_addr,
   output logic [31:0] wb_wr_data,
   output logic [31:0] retire_count
);

   logic [31:0] regs [0:31];
   logic [31:0] retire_q;

   always_comb begin
      if (wb_link)
         wb_wr_addr = LINK_REG;
      else if (wb_regdst)
         wb_wr_addr = wb_inst[15:11];
      else
         wb_wr_addr = wb_inst[20:16];
   end

   always_comb begin
      if (wb_link)
         wb_wr_data = {23'b0, wb_pc_4};
      else if (wb_memtoreg)
         wb_wr_data = wb_mem_data;
      else
         wb_wr_data = wb_alu_data;
   end

   assign wb_wr_en = wb_regwrite & ~wb_stall & (wb_wr_addr != 5'd0);

   // regs[0] is only ever cleared; the read mux masks address 0 regardless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_wr_en) begin
         regs[wb_wr_addr] <= wb_wr_data;
      end
   end

   // Bypass is gated by reset so every read returns 0 while the file is held cleared.
   function automatic logic [31:0] rd_port(input logic [4:0] addr);
      if (addr == 5'd0)
         return 32'h0;
      else if (rst_n && wb_wr_en && addr == wb_wr_addr)
         return wb_wr_data;
      else
         return regs[addr];
   endfunction

   assign rd_data_a = rd_port(rd_addr_a);
   assign rd_data_b = rd_port(rd_addr_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retire_q <= '0;
      else if (!wb_stall && wb_inst != NOP)
         retire_q <= retire_q + 32'd1;
   end

   assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, bypass, load/link priority, $0, stall and counter wrap.
module tb_wb_regfile;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_stall, wb_memtoreg, wb_regwrite, wb_regdst, wb_link;
   logic [31:0] wb_alu_data, wb_mem_data, wb_inst;
   logic [8:0]  wb_pc_4;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b, wb_wr_data, retire_count;
   logic        wb_wr_en;
   logic [4:0]  wb_wr_addr;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [31:0] NOP     = 32'h0000_0020;
   localparam logic [31:0] ADD_R8  = 32'h0022_4020;  // add $8,$1,$2
   localparam logic [31:0] ADD_R5  = 32'h0022_2820;  // add $5,$1,$2
   localparam logic [31:0] ADD_R3  = 32'h0022_1820;  // add $3,$1,$2
   localparam logic [31:0] ADD_R0  = 32'h0022_0020;  // add $0,$1,$2
   localparam logic [31:0] LW_R9   = 32'h8C29_0000;  // lw $9,0($1)
   localparam logic [31:0] JAL     = 32'h0C00_0000;
   localparam logic [31:0] SW      = 32'hAC00_0000;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall), .wb_memtoreg(wb_memtoreg),
      .wb_regwrite(wb_regwrite), .wb_regdst(wb_regdst), .wb_link(wb_link),
      .wb_alu_data(wb_alu_data), .wb_mem_data(wb_mem_data), .wb_pc_4(wb_pc_4),
      .wb_inst(wb_inst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_wr_en(wb_wr_en),
      .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .retire_count(retire_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // one clock edge; return on the following falling edge so inputs change away from posedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      wb_stall = 0; wb_memtoreg = 0; wb_regwrite = 0; wb_regdst = 0; wb_link = 0;
      wb_alu_data = 0; wb_mem_data = 0; wb_pc_4 = 0; wb_inst = NOP;
   endtask

   initial begin
      rst_n = 0; idle(); rd_addr_a = 5; rd_addr_b = 0;
      @(negedge clk); #1;
      chk("reset_count", retire_count, 0);
      chk("reset_rd_a", rd_data_a, 0);
      chk("reset_wr_en", {31'b0, wb_wr_en}, 0);
      rst_n = 1;

      // R-type with same-cycle bypass on both ports
      wb_inst = ADD_R8; wb_regwrite = 1; wb_regdst = 1; wb_alu_data = 32'hDEAD_BEEF;
      rd_addr_a = 8; rd_addr_b = 8; #1;
      chk("rtype_wr_addr", {27'b0, wb_wr_addr}, 8);
      chk("bypass_a", rd_data_a, 32'hDEAD_BEEF);
      chk("bypass_b", rd_data_b, 32'hDEAD_BEEF);
      step(); idle(); #1;
      chk("rtype_commit", rd_data_a, 32'hDEAD_BEEF);
      chk("count_1", retire_count, 1);

      // load into $9
      wb_inst = LW_R9; wb_regwrite = 1; wb_memtoreg = 1; wb_mem_data = 32'hAA; wb_alu_data = 32'h777;
      step(); idle(); rd_addr_a = 9; #1;
      chk("load_commit", rd_data_a, 32'hAA);

      // link overrides memtoreg and destination
      wb_inst = JAL; wb_regwrite = 1; wb_link = 1; wb_memtoreg = 1; wb_pc_4 = 9'h1F4;
      wb_mem_data = 32'h1234; #1;
      chk("link_wr_data", wb_wr_data, 32'h1F4);
      chk("link_wr_addr", {27'b0, wb_wr_addr}, 31);
      step(); idle(); rd_addr_a = 31; rd_addr_b = 9; #1;
      chk("link_commit", rd_data_a, 32'h1F4);
      chk("link_r9_kept", rd_data_b, 32'hAA);
      chk("count_3", retire_count, 3);

      // $0 protection
      wb_inst = ADD_R0; wb_regwrite = 1; wb_regdst = 1; wb_alu_data = 32'hFFFF_FFFF; rd_addr_b = 0; #1;
      chk("r0_wr_en", {31'b0, wb_wr_en}, 0);
      chk("r0_read", rd_data_b, 0);
      step(); #1;
      chk("r0_after", rd_data_b, 0);

      // stall holds an ALU write to $3
      wb_inst = ADD_R3; wb_regwrite = 1; wb_regdst = 1; wb_alu_data = 32'h55; wb_stall = 1; rd_addr_a = 3; #1;
      chk("stall_wr_en", {31'b0, wb_wr_en}, 0);
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk("stall_r3", rd_data_a, 0);
         chk("stall_count", retire_count, 4);
      end
      wb_stall = 0; #1;
      chk("unstall_bypass", rd_data_a, 32'h55);
      step(); idle(); #1;
      chk("unstall_commit", rd_data_a, 32'h55);
      chk("unstall_count", retire_count, 5);

      // bubbles do not count
      for (int i = 0; i < 4; i++) step();
      #1 chk("nop_count", retire_count, 5);

      // stores count even without regwrite; read of $3 not bypassed
      wb_inst = SW; wb_alu_data = 32'h99;
      for (int i = 0; i < 10; i++) step();
      #1 chk("sw_count", retire_count, 15);
      chk("sw_r3_kept", rd_data_a, 32'h55);

      // reset mid-run clears registers and counter at once
      wb_inst = ADD_R5; wb_regwrite = 1; wb_regdst = 1; wb_alu_data = 32'h1234_5678;
      step(); idle(); rd_addr_a = 5; #1;
      chk("r5_written", rd_data_a, 32'h1234_5678);
      wb_inst = ADD_R5; wb_regwrite = 1; wb_regdst = 1; wb_alu_data = 32'hCAFE_0000; rd_addr_b = 5;
      rst_n = 0; #1;
      chk("rst_r5_a", rd_data_a, 0);
      chk("rst_r5_b", rd_data_b, 0);
      chk("rst_count", retire_count, 0);
      step(); idle(); rst_n = 1; #1;
      chk("post_rst_r5", rd_data_a, 0);
      chk("post_rst_count", retire_count, 0);

      // counter wrap via backdoor
      wb_inst = SW; wb_stall = 1;
      force dut.retire_q = 32'hFFFF_FFFF; #1;
      chk("wrap_preload", retire_count, 32'hFFFF_FFFF);
      release dut.retire_q;
      wb_stall = 0;
      step(); #1;
      chk("wrap_zero", retire_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. It sits directly after the MEM/WB pipeline register and consumes its outputs. It selects the write-back value and destination, and commits the value to a 32x32 register file. It serves the two decode-stage read ports, with write-through bypass, and counts retired instructions. The resolved write port is also exported so the forwarding unit sees the WB-stage result.

## Interface
- NOP, 32'h0000_0020, bubble encoding (add $0,$0,$0) that MEM/WB injects on reset and flush.
- LINK_REG, 31, destination register for link (jal/jalr) writes.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_stall  in  1  WB stage held; suppresses commit and counting.
- wb_memtoreg  in  1  select wb_mem_data (1) or wb_alu_data (0).
- wb_regwrite  in  1  instruction writes a register.
- wb_regdst  in  1  destination = inst[15:11] (1) or inst[20:16] (0).
- wb_link  in  1  link write: overrides data and destination.
- wb_alu_data  in  32  ALU result.
- wb_mem_data  in  32  load data, already aligned and extended.
- wb_pc_4  in  9  PC+4 of the instruction.
- wb_inst  in  32  instruction word.
- rd_addr_a, rd_addr_b  in  5 each  decode read addresses (rs, rt).
- rd_data_a, rd_data_b  out  32 each  read data.
- wb_wr_en  out  1  effective write enable this cycle.
- wb_wr_addr  out  5  effective destination.
- wb_wr_data  out  32  effective write data.
- retire_count  out  32  retired-instruction counter.

## Operation
- **Destination.** If wb_link, the destination is LINK_REG. Otherwise it is wb_inst[15:11] when wb_regdst, else wb_inst[20:16].
- **Data.** If wb_link, the data is {23'b0, wb_pc_4}. Otherwise it is wb_mem_data when wb_memtoreg, else wb_alu_data. wb_link has priority over wb_memtoreg.
- **Write enable.** wb_wr_en = wb_regwrite & ~wb_stall & (wb_wr_addr != 0).
- **Exported write port.** wb_wr_addr and wb_wr_data are combinational and always driven, even when wb_wr_en=0.
- **Commit.** On a rising edge with wb_wr_en=1, regs[wb_wr_addr] <= wb_wr_data.
- **Register $0.** Never written and always reads 0.
- **Reads.** Combinational. rd_data_x = 0 if rd_addr_x == 0. Otherwise it is wb_wr_data if wb_wr_en and rd_addr_x == wb_wr_addr (write-through bypass). Otherwise it is regs[rd_addr_x].
- **Retire counter.** Increments by 1 on a rising edge when ~wb_stall & (wb_inst != NOP).
  - The counter is independent of wb_regwrite: stores and branches count.
  - It wraps from 32'hFFFF_FFFF to 0 without saturation.
- **Stall.** While wb_stall=1, no register write and no count occur. The held instruction commits once, on the first cycle wb_stall drops.

## Timing
- **Reset.** While rst_n=0:
  - regs[0..31] = 0 and retire_count = 0.
  - Read outputs return 0 for every address.
  - wb_wr_* follow the inputs combinationally. With MEM/WB reset contents (all zero, inst=NOP), wb_wr_en=0.
- **Reset assertion mid-operation.** Clears state immediately. A write or count pending in that cycle is lost.
- **Reset deassertion.** The first edge after release behaves normally.
- **Write latency.** Register state updates at the edge ending the WB cycle.
- **Read latency.** Bypass makes the value visible to a same-cycle read: zero-cycle read-after-write.
- **Simultaneous events.**
  - Both read ports may hit the bypass at once, and both return wb_wr_data.
  - A read of the write address while wb_wr_en=0 (stalled or regwrite=0) returns the old value.
- **Combinational paths.** No combinational path from rd_addr_* to wb_wr_*. The path from wb_* inputs to rd_data_* is combinational, through the bypass.

## Test plan
- **Reset.** Assert rst_n=0 mid-run after writing $5 = 32'h1234_5678 -> rd_data_a for addr 5 reads 0 immediately; retire_count = 0.
- **R-type and bypass.** wb_regwrite=1, wb_regdst=1, inst[15:11]=8, wb_alu_data=32'hDEAD_BEEF, rd_addr_a=8 in the same cycle -> rd_data_a = 32'hDEAD_BEEF before the edge. After the edge, with regwrite=0, it still reads 32'hDEAD_BEEF.
- **Load vs link priority.**
  - wb_memtoreg=1, regdst=0, inst[20:16]=9, mem_data=32'h0000_00AA -> $9 = 32'hAA.
  - Then link=1, memtoreg=1, pc_4=9'h1F4 -> $31 = 32'h0000_01F4 and $9 is unchanged.
- **$0 protection.** regwrite=1, destination 0, data 32'hFFFF_FFFF -> wb_wr_en=0; rd_data_b for addr 0 = 0.
- **Stall.** Hold an ALU write of 32'h55 to $3 with wb_stall=1 for 3 cycles -> $3 is unchanged and retire_count is constant. On stall release, one write and exactly +1 to the count.
- **Counter.**
  - NOP bubbles for 4 cycles -> no increment.
  - 10 non-NOP instructions -> +10.
  - Force the counter to 32'hFFFF_FFFF via 2^32-1 retires (or a bench backdoor), then one retire -> 0.
